// File: rtl/dab_modulador.sv
// dab_modulador: triple-phase-shift gate generator for a dual active bridge.
// 1024-step carrier, shadowed set-points, per-leg dead time.
module dab_modulador #(
  parameter int CLK_DIV = 1,
  parameter int DT      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  logic [8:0] tau1,
  input  logic [8:0] tau2,
  input  logic [8:0] phi,
  input  logic [1:0] modo,
  input  logic       trip,
  output logic [1:0] g1_hi,
  output logic [1:0] g1_lo,
  output logic [1:0] g2_hi,
  output logic [1:0] g2_lo,
  output logic       sync,
  output logic       run
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [3:0] DTV = 4'(DT);

  logic [PW-1:0] r_pre;
  logic [9:0]    r_cnt;
  logic          r_sync;

  logic [8:0] r_p_tau1;
  logic [8:0] r_p_tau2;
  logic [8:0] r_p_phi;
  logic [1:0] r_p_modo;
  logic [8:0] r_sh_tau1;
  logic [8:0] r_sh_tau2;
  logic [8:0] r_sh_phi;
  logic [1:0] r_sh_modo;

  logic       r_act;
  logic [3:0] r_s;
  logic [3:0] r_hi;
  logic [3:0] r_lo;
  logic [3:0] r_dt [4];

  logic       w_step;
  logic       w_wrap;
  logic       w_run;
  logic [9:0] w_c2;
  logic [9:0] w_d1;
  logic [9:0] w_d2;
  logic [3:0] w_s;

  assign w_step = (r_pre == PMAX);
  assign w_wrap = w_step && (r_cnt == 10'd1023);
  assign w_run  = r_sh_modo[0] ^ r_sh_modo[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_sync <= 1'b0;
    end else begin
      r_pre  <= w_step ? '0 : r_pre + 1'b1;
      r_sync <= w_wrap;
      if (w_step) begin
        r_cnt <= r_cnt + 10'd1;
      end
    end
  end

  // Shadow copies the old pending value when upd lands on the wrap clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_tau1  <= '0;
      r_p_tau2  <= '0;
      r_p_phi   <= '0;
      r_p_modo  <= '0;
      r_sh_tau1 <= '0;
      r_sh_tau2 <= '0;
      r_sh_phi  <= '0;
      r_sh_modo <= '0;
    end else if (trip) begin
      r_p_modo  <= '0;
      r_sh_modo <= '0;
    end else begin
      if (w_wrap) begin
        r_sh_tau1 <= r_p_tau1;
        r_sh_tau2 <= r_p_tau2;
        r_sh_phi  <= r_p_phi;
        r_sh_modo <= r_p_modo;
      end
      if (upd) begin
        r_p_tau1 <= tau1;
        r_p_tau2 <= tau2;
        r_p_phi  <= phi;
        r_p_modo <= modo;
      end
    end
  end

  assign w_c2 = r_sh_modo[1] ? r_cnt + {1'b0, r_sh_phi}
                             : r_cnt - {1'b0, r_sh_phi};
  assign w_d1 = r_cnt - {1'b0, r_sh_tau1};
  assign w_d2 = w_c2 - {1'b0, r_sh_tau2};
  assign w_s  = {~w_d2[9], ~w_c2[9], ~w_d1[9], ~r_cnt[9]};

  // Legs 0..3 = 1A, 1B, 2A, 2B; first run cycle is treated as a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act <= 1'b0;
      r_s   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_dt[i] <= '0;
      end
    end else if (trip || !w_run) begin
      r_act <= 1'b0;
      r_s   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_dt[i] <= '0;
      end
    end else begin
      r_act <= 1'b1;
      r_s   <= w_s;
      for (int i = 0; i < 4; i++) begin
        if (!r_act || (w_s[i] != r_s[i])) begin
          if (DTV == 4'd0) begin
            r_hi[i] <= w_s[i];
            r_lo[i] <= ~w_s[i];
            r_dt[i] <= '0;
          end else begin
            r_hi[i] <= 1'b0;
            r_lo[i] <= 1'b0;
            r_dt[i] <= DTV;
          end
        end else if (r_dt[i] == 4'd1) begin
          r_dt[i] <= '0;
          r_hi[i] <= r_s[i];
          r_lo[i] <= ~r_s[i];
        end else if (r_dt[i] != 4'd0) begin
          r_dt[i] <= r_dt[i] - 4'd1;
        end
      end
    end
  end

  assign g1_hi = r_hi[1:0];
  assign g1_lo = r_lo[1:0];
  assign g2_hi = r_hi[3:2];
  assign g2_lo = r_lo[3:2];
  assign sync  = r_sync;
  assign run   = w_run;

endmodule

// File: tb/tb_dab_modulador.sv
// tb_dab_modulador: self-checking bench for dab_modulador.
// Vector table through a scoreboard queue plus hand-written corner sequences.
module tb_dab_modulador;

  logic       clk;
  logic       rst_n;
  logic       upd;
  logic [8:0] tau1;
  logic [8:0] tau2;
  logic [8:0] phi;
  logic [1:0] modo;
  logic       trip;
  logic [1:0] g1_hi;
  logic [1:0] g1_lo;
  logic [1:0] g2_hi;
  logic [1:0] g2_lo;
  logic       sync;
  logic       run;

  dab_modulador #(.CLK_DIV(1), .DT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .upd   (upd),
    .tau1  (tau1),
    .tau2  (tau2),
    .phi   (phi),
    .modo  (modo),
    .trip  (trip),
    .g1_hi (g1_hi),
    .g1_lo (g1_lo),
    .g2_hi (g2_hi),
    .g2_lo (g2_lo),
    .sync  (sync),
    .run   (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] t1;
    logic [8:0] t2;
    logic [8:0] ph;
    logic [1:0] md;
    int         r1a;
    int         r1b;
    int         r2a;
    int         r2b;
  } vec_t;

  vec_t vecs [5];
  vec_t sbq [$];
  vec_t e;

  int npass;
  int ntot;
  int m_rise [4];
  int m_hic [4];
  int m_ngap;
  int m_gbad;
  int m_ovl;
  int len;
  int act;
  bit ok;

  task automatic chk(input string name, input int got, input int want);
    ntot++;
    if (got == want) npass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sync(output bit okk);
    okk = 1'b0;
    for (int k = 0; k < 2100 && !okk; k++) begin
      @(negedge clk);
      if (sync) okk = 1'b1;
    end
    if (!okk) begin
      ntot++;
      $display("FAIL sync_timeout: got no sync want sync within 2100 clks");
    end
  endtask

  task automatic do_upd(input logic [8:0] a, input logic [8:0] b,
                        input logic [8:0] p, input logic [1:0] m);
    tau1 = a; tau2 = b; phi = p; modo = m; upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic run_period(output int l, output int a);
    l = 0;
    a = 0;
    for (int k = 1; k <= 1100 && l == 0; k++) begin
      if (|{g1_hi, g1_lo, g2_hi, g2_lo}) a++;
      @(negedge clk);
      if (sync) l = k;
    end
  endtask

  // Called at the sync sample (i=0); runs a little past the period end
  // so gaps starting late in the window complete.
  task automatic measure();
    logic [3:0] hi;
    logic [3:0] lo;
    logic [3:0] ph;
    logic [3:0] pa;
    int gap [4];
    ph = '0;
    pa = 4'hF;
    m_ngap = 0;
    m_gbad = 0;
    m_ovl = 0;
    for (int j = 0; j < 4; j++) begin
      m_rise[j] = -1;
      m_hic[j] = 0;
      gap[j] = -1;
    end
    for (int i = 0; i < 1034; i++) begin
      if (i > 0) @(negedge clk);
      hi = {g2_hi, g1_hi};
      lo = {g2_lo, g1_lo};
      for (int j = 0; j < 4; j++) begin
        if (i < 1024) begin
          if (hi[j]) m_hic[j]++;
          if (i > 0 && hi[j] && !ph[j] && m_rise[j] < 0) m_rise[j] = i;
        end
        if (hi[j] && lo[j]) m_ovl++;
        if (!hi[j] && !lo[j]) begin
          if (pa[j]) gap[j] = (i < 1024) ? 1 : -1;
          else if (gap[j] >= 0) gap[j]++;
        end else if (gap[j] >= 0) begin
          m_ngap++;
          if (gap[j] != 4) m_gbad++;
          gap[j] = -1;
        end
      end
      ph = hi;
      pa = hi | lo;
    end
  endtask

  initial begin
    npass = 0;
    ntot = 0;
    vecs[0] = '{9'd0,   9'd0,   9'd0,   2'b01, 5, 5,   5,   5};
    vecs[1] = '{9'd0,   9'd0,   9'd128, 2'b01, 5, 5,   133, 133};
    vecs[2] = '{9'd0,   9'd0,   9'd128, 2'b10, 5, 5,   901, 901};
    vecs[3] = '{9'd200, 9'd50,  9'd100, 2'b01, 5, 205, 105, 155};
    vecs[4] = '{9'd500, 9'd300, 9'd511, 2'b10, 5, 505, 518, 818};

    rst_n = 1'b0; upd = 1'b0; trip = 1'b0;
    tau1 = '0; tau2 = '0; phi = '0; modo = '0;
    adv(3);
    chk("reset_gates", int'({g1_hi, g1_lo, g2_hi, g2_lo}), 0);
    chk("reset_sync", int'(sync), 0);
    chk("reset_run", int'(run), 0);
    rst_n = 1'b1;

    wait_sync(ok);
    run_period(len, act);
    chk("off_gates", act, 0);
    chk("sync_period", len, 1024);
    chk("off_run", int'(run), 0);

    do_upd(9'd0, 9'd0, 9'd0, 2'b01);
    wait_sync(ok);
    measure();
    chk("start_1A_rise", m_rise[0], 5);
    chk("start_2A_rise", m_rise[2], 5);
    chk("start_overlap", m_ovl, 0);
    chk("start_run", int'(run), 1);

    for (int v = 0; v < 5; v++) begin
      do_upd(vecs[v].t1, vecs[v].t2, vecs[v].ph, vecs[v].md);
      sbq.push_back(vecs[v]);
      wait_sync(ok);
      wait_sync(ok);
      measure();
      e = sbq.pop_front();
      chk($sformatf("v%0d_rise_1A", v), m_rise[0], e.r1a);
      chk($sformatf("v%0d_rise_1B", v), m_rise[1], e.r1b);
      chk($sformatf("v%0d_rise_2A", v), m_rise[2], e.r2a);
      chk($sformatf("v%0d_rise_2B", v), m_rise[3], e.r2b);
      for (int j = 0; j < 4; j++)
        chk($sformatf("v%0d_hicnt_leg%0d", v, j), m_hic[j], 508);
      chk($sformatf("v%0d_ngaps", v), m_ngap, 8);
      chk($sformatf("v%0d_gap_bad", v), m_gbad, 0);
      chk($sformatf("v%0d_overlap", v), m_ovl, 0);
    end

    do_upd(9'd0, 9'd0, 9'd0, 2'b01);
    wait_sync(ok);
    wait_sync(ok);
    adv(400);
    do_upd(9'd300, 9'd0, 9'd0, 2'b01);
    adv(299);
    chk("midupd_old_tau", int'(g1_hi[1]), 0);
    adv(200);
    do_upd(9'd100, 9'd0, 9'd0, 2'b01);
    wait_sync(ok);
    measure();
    chk("midupd_new_tau", m_rise[1], 105);

    wait_sync(ok);
    adv(1023);
    do_upd(9'd200, 9'd0, 9'd0, 2'b01);
    chk("wrapupd_sync", int'(sync), 1);
    measure();
    chk("wrapupd_still_old", m_rise[1], 105);
    wait_sync(ok);
    measure();
    chk("wrapupd_applied", m_rise[1], 205);

    wait_sync(ok);
    adv(700);
    trip = 1'b1;
    @(negedge clk);
    trip = 1'b0;
    chk("trip_gates", int'({g1_hi, g1_lo, g2_hi, g2_lo}), 0);
    chk("trip_run", int'(run), 0);
    trip = 1'b1;
    do_upd(9'd0, 9'd0, 9'd0, 2'b01);
    trip = 1'b0;
    wait_sync(ok);
    run_period(len, act);
    chk("trip_hold_gates", act, 0);
    chk("trip_sync_period", len, 1024);
    do_upd(9'd0, 9'd0, 9'd0, 2'b01);
    wait_sync(ok);
    measure();
    chk("recover_1A_rise", m_rise[0], 5);
    chk("recover_run", int'(run), 1);

    wait_sync(ok);
    adv(300);
    chk("pre_reset_1A", int'(g1_hi[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_gates", int'({g1_hi, g1_lo, g2_hi, g2_lo}), 0);
    chk("async_reset_run", int'(run), 0);
    adv(2);
    rst_n = 1'b1;
    adv(2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
